// File: rtl/prog_loader_crypt_pkg.sv
// prog_loader_crypt_pkg
//  Shared types and constants for the boot-time program loader.
//  - state_e      : loader FSM states
//  - KEY_IDX_W    : width of the key-ROM index
//  - LEN_W        : width of the frame word-count header
//  - accepts_rx() : states in which the loader takes input bytes
package prog_loader_crypt_pkg;

  localparam int KEY_IDX_W = 4;
  localparam int LEN_W     = 16;

  typedef enum logic [2:0] {
    ST_LEN0,
    ST_LEN1,
    ST_DATA,
    ST_KEY,
    ST_WRITE,
    ST_CHK,
    ST_DONE,
    ST_ERR
  } state_e;

  function automatic logic accepts_rx(state_e s);
    return (s inside {ST_LEN0, ST_LEN1, ST_DATA, ST_CHK});
  endfunction

endpackage

// File: rtl/prog_loader_crypt_if.sv
// prog_loader_crypt_if
//  Groups the loader's bus-style connections:
//  - byte stream in  : rx_valid, rx_data, rx_ready (transfer = valid & ready)
//  - key ROM         : key_addr out, key_data in (synchronous ROM, 1-cycle latency)
//  - instruction RAM : imem_we, imem_addr (byte address), imem_wdata (encrypted word)
//  Modports:
//  - slave  : the loader itself
//  - master : the environment (byte source, key ROM, instruction RAM)
interface prog_loader_crypt_if;
  import prog_loader_crypt_pkg::*;

  logic                 rx_valid;
  logic [7:0]           rx_data;
  logic                 rx_ready;
  logic [KEY_IDX_W-1:0] key_addr;
  logic [31:0]          key_data;
  logic                 imem_we;
  logic [31:0]          imem_addr;
  logic [31:0]          imem_wdata;

  modport slave (
    input  rx_valid, rx_data, key_data,
    output rx_ready, key_addr, imem_we, imem_addr, imem_wdata
  );

  modport master (
    output rx_valid, rx_data, key_data,
    input  rx_ready, key_addr, imem_we, imem_addr, imem_wdata
  );

endinterface

// File: rtl/prog_loader_crypt_byte_asm.sv
// prog_loader_crypt_byte_asm
//  Assembles little-endian 32-bit words from a byte stream and keeps a
//  running XOR of every byte it takes in.
//  Ports:
//  - clk_i, rst_i : clock, synchronous active-high reset
//  - byte_en      : byte_data is consumed this cycle
//  - byte_data    : incoming byte
//  - word         : assembled word (first byte received ends up in [7:0])
//  - word_valid   : high in the cycle the 4th byte of a word is consumed
//  - chk          : XOR of all bytes consumed since reset
module prog_loader_crypt_byte_asm (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        byte_en,
  input  logic [7:0]  byte_data,
  output logic [31:0] word,
  output logic        word_valid,
  output logic [7:0]  chk
);

  logic [1:0]  byte_cnt;
  logic [31:0] word_q;
  logic [7:0]  chk_q;

  // New bytes enter at the top so that after four shifts the first byte of
  // the word sits in the least significant lane.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      byte_cnt <= 2'd0;
      word_q   <= 32'd0;
      chk_q    <= 8'd0;
    end else if (byte_en) begin
      byte_cnt <= byte_cnt + 2'd1;
      word_q   <= {byte_data, word_q[31:8]};
      chk_q    <= chk_q ^ byte_data;
    end
  end

  assign word       = word_q;
  assign word_valid = byte_en && (byte_cnt == 2'd3);
  assign chk        = chk_q;

endmodule

// File: rtl/prog_loader_crypt.sv
// prog_loader_crypt
//  Boot-time program loader. Receives a framed byte stream
//  (LEN_LO, LEN_HI, N x 4-byte LE words, optional checksum byte), encrypts
//  each word by XOR with the key-ROM word indexed by address bits
//  [KEY_LSB+3:KEY_LSB], writes it to instruction RAM and releases the CPU
//  only once the whole frame has been loaded correctly.
//  Configuration macro: LOADER_CHKSUM_EN -- when defined a checksum byte
//  (XOR of all plaintext payload bytes) follows the payload and a mismatch
//  sends the loader to ERR.
//  Ports:
//  - clk_i, rst_i : clock, synchronous active-high reset
//  - bus          : byte stream, key ROM and instruction RAM (slave modport)
//  - busy_o       : frame in progress (after LEN_LO, before DONE/ERR)
//  - done_o       : frame loaded, sticky until reset
//  - err_o        : frame rejected, sticky until reset
//  - cpu_run_o    : releases the core (drives its active-low reset)
module prog_loader_crypt
  import prog_loader_crypt_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0,
  parameter int          MAX_WORDS = 64,
  parameter int          KEY_LSB   = 4
) (
  input  logic                clk_i,
  input  logic                rst_i,
  prog_loader_crypt_if.slave  bus,
  output logic                busy_o,
  output logic                done_o,
  output logic                err_o,
  output logic                cpu_run_o
);

  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_WORDS);

`ifdef LOADER_CHKSUM_EN
  localparam state_e PAYLOAD_END = ST_CHK;
`else
  localparam state_e PAYLOAD_END = ST_DONE;
`endif

  state_e           state, state_nxt;
  logic [7:0]       len_lo;
  logic [LEN_W-1:0] word_total;
  logic [LEN_W-1:0] word_cnt;
  logic [LEN_W-1:0] word_cnt_inc;
  logic [LEN_W-1:0] hdr_len;
  logic [31:0]      addr_q;
  logic             rx_fire;
  logic [31:0]      asm_word;
  logic             asm_word_valid;
  logic [7:0]       payload_xor;

  assign rx_fire      = bus.rx_valid && bus.rx_ready;
  assign hdr_len      = {bus.rx_data, len_lo};
  assign word_cnt_inc = word_cnt + 16'd1;

  prog_loader_crypt_byte_asm u_byte_asm (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .byte_en    (rx_fire && (state == ST_DATA)),
    .byte_data  (bus.rx_data),
    .word       (asm_word),
    .word_valid (asm_word_valid),
    .chk        (payload_xor)
  );

`ifndef LOADER_CHKSUM_EN
  logic unused_payload_xor;
  assign unused_payload_xor = ^payload_xor;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= ST_LEN0;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_LEN0: begin
        if (rx_fire) state_nxt = ST_LEN1;
      end
      ST_LEN1: begin
        if (rx_fire) begin
          if (hdr_len == '0) begin
            state_nxt = PAYLOAD_END;
          end else if (hdr_len > MAX_LEN) begin
            state_nxt = ST_ERR;
          end else begin
            state_nxt = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        if (asm_word_valid) state_nxt = ST_KEY;
      end
      // The key ROM address is presented here; its data arrives in WRITE.
      ST_KEY: begin
        state_nxt = ST_WRITE;
      end
      ST_WRITE: begin
        state_nxt = (word_cnt_inc == word_total) ? PAYLOAD_END : ST_DATA;
      end
      ST_CHK: begin
`ifdef LOADER_CHKSUM_EN
        if (rx_fire) state_nxt = (bus.rx_data == payload_xor) ? ST_DONE : ST_ERR;
`else
        state_nxt = ST_ERR;
`endif
      end
      ST_DONE: state_nxt = ST_DONE;
      ST_ERR:  state_nxt = ST_ERR;
      default: state_nxt = ST_ERR;
    endcase
  end

  // Header capture and per-word address/count advance. The address is
  // allowed to wrap modulo 2^32.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      len_lo     <= 8'd0;
      word_total <= '0;
      word_cnt   <= '0;
      addr_q     <= BASE_ADDR;
    end else begin
      if ((state == ST_LEN0) && rx_fire) len_lo <= bus.rx_data;
      if ((state == ST_LEN1) && rx_fire) word_total <= hdr_len;
      if (state == ST_WRITE) begin
        addr_q   <= addr_q + 32'd4;
        word_cnt <= word_cnt_inc;
      end
    end
  end

  assign bus.rx_ready   = accepts_rx(state);
  assign bus.key_addr   = addr_q[KEY_LSB +: KEY_IDX_W];
  assign bus.imem_addr  = addr_q;
  assign bus.imem_we    = (state == ST_WRITE);
  assign bus.imem_wdata = asm_word ^ bus.key_data;

  assign busy_o    = state inside {ST_LEN1, ST_DATA, ST_KEY, ST_WRITE, ST_CHK};
  assign done_o    = (state == ST_DONE);
  assign cpu_run_o = (state == ST_DONE);
  assign err_o     = (state == ST_ERR);

endmodule
